// File: rtl/byteswap_control_s_axi_pkg.sv
// byteswap_control_s_axi_pkg: register map, CTRL bit positions and FSM state types for the byteswap control slave
package byteswap_ctrl_pkg;
  localparam logic [5:0] ADDR_CTRL      = 6'h00;
  localparam logic [5:0] ADDR_GIE       = 6'h04;
  localparam logic [5:0] ADDR_IER       = 6'h08;
  localparam logic [5:0] ADDR_ISR       = 6'h0C;
  localparam logic [5:0] ADDR_XFER_SIZE = 6'h10;
  localparam logic [5:0] ADDR_GMEM_LO   = 6'h18;
  localparam logic [5:0] ADDR_GMEM_HI   = 6'h1C;
  localparam int CTRL_AP_START     = 0;
  localparam int CTRL_AP_DONE      = 1;
  localparam int CTRL_AP_IDLE      = 2;
  localparam int CTRL_AP_READY     = 3;
  localparam int CTRL_AUTO_RESTART = 7;
  typedef enum logic [1:0] {WRIDLE, WRDATA, WRRESP} wr_state_t;
  typedef enum logic {RDIDLE, RDDATA} rd_state_t;
  function automatic logic [3:0] word_of(input logic [5:0] a);
    return a[5:2];
  endfunction
  function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = strb[i] ? data[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/byteswap_control_s_axi_if.sv
// byteswap_control_s_axi_if: AXI4-Lite control bus between host and the byteswap control slave
interface byteswap_control_s_axi_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/byteswap_control_s_axi.sv
// byteswap_control_s_axi: AXI4-Lite register file driving ap_start and kernel arguments, collecting status and interrupt
module byteswap_control_s_axi
  import byteswap_ctrl_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH   = 6,
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int C_XFER_SIZE_WIDTH    = 32,
  parameter int C_M00_AXI_ADDR_WIDTH = 64
) (
  input  logic                            ap_clk,
  input  logic                            areset,
  byteswap_control_s_axi_if.slave         s_axi_control,
  output logic                            interrupt,
  output logic                            ap_start,
  input  logic                            ap_done,
  input  logic                            ap_idle,
  input  logic                            ap_ready,
  output logic [C_XFER_SIZE_WIDTH-1:0]    xfer_size_bytes,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0] gmem_ptr
);
  wr_state_t wstate;
  rd_state_t rstate;
  logic [C_S_AXI_ADDR_WIDTH-1:2] waddr;
  logic [3:0] raddr;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic wr_en, ar_hs;
  logic wr_ctrl, wr_gie, wr_ier, wr_isr, wr_xfer, wr_lo, wr_hi;
  logic done, auto_restart, gie;
  logic [1:0] ier, isr;
  logic [31:0] ctrl_rd;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_next;
  assign s_axi_control.bresp = 2'b00;
  assign s_axi_control.rresp = 2'b00;
  assign wdata = s_axi_control.wdata;
  assign wstrb = s_axi_control.wstrb;
  assign raddr = s_axi_control.araddr[5:2];
  assign wr_en = s_axi_control.wvalid & s_axi_control.wready;
  assign ar_hs = s_axi_control.arvalid & s_axi_control.arready;
  assign wr_ctrl = wr_en && waddr == word_of(ADDR_CTRL) && wstrb[0];
  assign wr_gie  = wr_en && waddr == word_of(ADDR_GIE) && wstrb[0];
  assign wr_ier  = wr_en && waddr == word_of(ADDR_IER) && wstrb[0];
  assign wr_isr  = wr_en && waddr == word_of(ADDR_ISR) && wstrb[0];
  assign wr_xfer = wr_en && waddr == word_of(ADDR_XFER_SIZE);
  assign wr_lo   = wr_en && waddr == word_of(ADDR_GMEM_LO);
  assign wr_hi   = wr_en && waddr == word_of(ADDR_GMEM_HI);
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      wstate <= WRIDLE;
      waddr <= '0;
      s_axi_control.awready <= 1'b0;
      s_axi_control.wready <= 1'b0;
      s_axi_control.bvalid <= 1'b0;
    end else begin
      case (wstate)
        WRIDLE: begin
          s_axi_control.awready <= 1'b1;
          if (s_axi_control.awvalid && s_axi_control.awready) begin
            waddr <= s_axi_control.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
            s_axi_control.awready <= 1'b0;
            s_axi_control.wready <= 1'b1;
            wstate <= WRDATA;
          end
        end
        WRDATA: if (s_axi_control.wvalid) begin
          s_axi_control.wready <= 1'b0;
          s_axi_control.bvalid <= 1'b1;
          wstate <= WRRESP;
        end
        WRRESP: if (s_axi_control.bready) begin
          s_axi_control.bvalid <= 1'b0;
          s_axi_control.awready <= 1'b1;
          wstate <= WRIDLE;
        end
        default: wstate <= WRIDLE;
      endcase
    end
  end
  // done bypass: a done pulse coinciding with the clearing read is still reported
  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CTRL_AP_START] = ap_start;
    ctrl_rd[CTRL_AP_DONE] = done | ap_done;
    ctrl_rd[CTRL_AP_IDLE] = ap_idle;
    ctrl_rd[CTRL_AP_READY] = ap_ready;
    ctrl_rd[CTRL_AUTO_RESTART] = auto_restart;
    rdata_next = raddr == word_of(ADDR_CTRL)      ? ctrl_rd :
                 raddr == word_of(ADDR_GIE)       ? {31'b0, gie} :
                 raddr == word_of(ADDR_IER)       ? {30'b0, ier} :
                 raddr == word_of(ADDR_ISR)       ? {30'b0, isr} :
                 raddr == word_of(ADDR_XFER_SIZE) ? xfer_size_bytes :
                 raddr == word_of(ADDR_GMEM_LO)   ? gmem_ptr[31:0] :
                 raddr == word_of(ADDR_GMEM_HI)   ? gmem_ptr[63:32] : '0;
  end
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      rstate <= RDIDLE;
      s_axi_control.arready <= 1'b0;
      s_axi_control.rvalid <= 1'b0;
      s_axi_control.rdata <= '0;
    end else begin
      case (rstate)
        RDIDLE: begin
          s_axi_control.arready <= 1'b1;
          if (ar_hs) begin
            s_axi_control.rdata <= rdata_next;
            s_axi_control.arready <= 1'b0;
            s_axi_control.rvalid <= 1'b1;
            rstate <= RDDATA;
          end
        end
        RDDATA: if (s_axi_control.rready) begin
          s_axi_control.rvalid <= 1'b0;
          s_axi_control.arready <= 1'b1;
          rstate <= RDIDLE;
        end
        default: rstate <= RDIDLE;
      endcase
    end
  end
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      ap_start <= 1'b0;
      auto_restart <= 1'b0;
      done <= 1'b0;
      gie <= 1'b0;
      ier <= 2'b00;
      isr <= 2'b00;
      interrupt <= 1'b0;
      xfer_size_bytes <= '0;
      gmem_ptr <= '0;
    end else begin
      if (wr_ctrl && wdata[CTRL_AP_START]) ap_start <= 1'b1;
      else if (ap_ready && !auto_restart) ap_start <= 1'b0;
      if (wr_ctrl) auto_restart <= wdata[CTRL_AUTO_RESTART];
      if (ap_done) done <= 1'b1;
      else if (ar_hs && raddr == word_of(ADDR_CTRL)) done <= 1'b0;
      if (wr_gie) gie <= wdata[0];
      if (wr_ier) ier <= wdata[1:0];
      isr[0] <= (ap_done & ier[0]) | (isr[0] ^ (wr_isr & wdata[0]));
      isr[1] <= (ap_ready & ier[1]) | (isr[1] ^ (wr_isr & wdata[1]));
      interrupt <= gie & (isr[0] | isr[1]);
      if (wr_xfer) xfer_size_bytes <= apply_strb(xfer_size_bytes, wdata, wstrb);
      if (wr_lo) gmem_ptr[31:0] <= apply_strb(gmem_ptr[31:0], wdata, wstrb);
      if (wr_hi) gmem_ptr[63:32] <= apply_strb(gmem_ptr[63:32], wdata, wstrb);
    end
  end
endmodule
